// File: rtl/trig_pulse_sched.sv
// ---------------------------------------------------------------------------
// trig_pulse_sched
//
// Purpose:
//    Schedules one trigger at a time from a bank of per-channel pulse
//    sources. While ARMED, every channel's edge detector is enabled through
//    valid_out. The first cycle with any pulse grants exactly one channel.
//    That grant produces a single-cycle trig_out carrying the channel index,
//    then holds everything off for DEADTIME cycles. Every pulse that does not
//    become a trigger is counted in a saturating drop counter.
//
// Configuration macro:
//    TRIG_RR_EN  - defined: round-robin arbitration with a rotating pointer.
//                  undefined (default): fixed priority, lowest index wins.
//
// Parameters:
//    NCH       number of pulse channels (2..16)
//    DEADTIME  dead-time length in clk cycles (1..65535)
//    CNTW      width of the drop counter
//
// Ports:
//    clk        in   single clock, rising edge
//    reset      in   asynchronous active-high reset
//    enable     in   run request; low sends the block to IDLE
//    pulse_in   in   [NCH] single-cycle pulses from the edge detectors
//    valid_out  out  [NCH] arm signals to the edge detectors (ARMED only)
//    trig_out   out  one-cycle scheduled trigger
//    trig_ch    out  [clog2(NCH)] granted channel, valid while trig_out=1
//    busy       out  high while in DEAD
//    drop_clr   in   synchronous clear of drop_count
//    drop_count out  [CNTW] saturating count of discarded pulses
// ---------------------------------------------------------------------------
module trig_pulse_sched #(
   parameter int NCH      = 4,
   parameter int DEADTIME = 16,
   parameter int CNTW     = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [NCH-1:0]           pulse_in,
   output logic [NCH-1:0]           valid_out,
   output logic                     trig_out,
   output logic [$clog2(NCH)-1:0]   trig_ch,
   output logic                     busy,
   input  logic                     drop_clr,
   output logic [CNTW-1:0]          drop_count
);

   localparam int CHW = $clog2(NCH);
   localparam int PCW = $clog2(NCH + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ARMED = 2'd1;
   localparam logic [1:0] DEAD  = 2'd2;

   // The dead counter counts down to zero, so it is loaded with one less
   // than the dead-time to give exactly DEADTIME cycles in DEAD.
   localparam logic [15:0] DEAD_LOAD = 16'(DEADTIME - 1);

   logic [1:0]       state_q, state_d;
   logic [15:0]      deadCnt_q, deadCnt_d;
   logic             trigOut_q, trigOut_d;
   logic [CHW-1:0]   trigCh_q, trigCh_d;
   logic [CNTW-1:0]  dropCnt_q, dropCnt_d;

   logic             anyPulse;
   logic             grantFire;
   logic [CHW-1:0]   grantIdx;
   logic [PCW-1:0]   pulseCount;
   logic [PCW-1:0]   dropInc;
   logic [CNTW:0]    dropSum;

   assign anyPulse = |pulse_in;

   // A grant only happens from ARMED with enable still high; enable falling
   // in the same cycle as a pulse wins, so that pulse becomes a drop.
   assign grantFire = (state_q == ARMED) && enable && anyPulse;

   // Number of channels pulsing this cycle, used to size the drop increment.
   always_comb begin
      pulseCount = '0;
      for (int i = 0; i < NCH; i++) begin
         pulseCount = pulseCount + PCW'(pulse_in[CHW'(i)]);
      end
   end

`ifdef TRIG_RR_EN
   logic [CHW-1:0]   ptr_q, ptr_d;
   logic [CHW:0]     candSum;
   logic [CHW-1:0]   cand;
   logic             found;

   // Round-robin search: walk the channels starting at the pointer, wrapping
   // modulo NCH, and take the first one with a pulse. The extra sum bit
   // handles the wrap for channel counts that are not a power of two.
   always_comb begin
      grantIdx = '0;
      found    = 1'b0;
      candSum  = '0;
      cand     = '0;
      for (int i = 0; i < NCH; i++) begin
         candSum = {1'b0, ptr_q} + (CHW+1)'(i);
         if (candSum >= (CHW+1)'(NCH)) begin
            candSum = candSum - (CHW+1)'(NCH);
         end
         cand = candSum[CHW-1:0];
         if (!found && pulse_in[cand]) begin
            found    = 1'b1;
            grantIdx = cand;
         end
      end
   end

   // After granting channel k the search restarts at k+1, wrapping to 0.
   always_comb begin
      ptr_d = ptr_q;
      if (grantFire) begin
         if (grantIdx == CHW'(NCH - 1)) begin
            ptr_d = '0;
         end else begin
            ptr_d = grantIdx + CHW'(1);
         end
      end
   end

   // Pointer register; cleared by reset so arbitration restarts at channel 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   // Fixed priority: scanning from the top down leaves the lowest pulsing
   // index in grantIdx.
   always_comb begin
      grantIdx = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (pulse_in[CHW'(i)]) begin
            grantIdx = CHW'(i);
         end
      end
   end
`endif

   // State sequencing. Enable low overrides everything and aborts any dead
   // time in progress; DEAD is never resumed, re-arming always goes through
   // IDLE. By default every incoming pulse is a drop; only the grant cycle
   // keeps one pulse back as the trigger.
   always_comb begin
      state_d   = state_q;
      deadCnt_d = deadCnt_q;
      trigOut_d = 1'b0;
      trigCh_d  = trigCh_q;
      dropInc   = pulseCount;
      if (!enable) begin
         state_d   = IDLE;
         deadCnt_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = ARMED;
            end
            ARMED: begin
               if (anyPulse) begin
                  state_d   = DEAD;
                  deadCnt_d = DEAD_LOAD;
                  trigOut_d = 1'b1;
                  trigCh_d  = grantIdx;
                  dropInc   = pulseCount - PCW'(1);
               end
            end
            DEAD: begin
               if (deadCnt_q == 16'd0) begin
                  state_d = ARMED;
               end else begin
                  deadCnt_d = deadCnt_q - 16'd1;
               end
            end
            default: begin
               state_d   = IDLE;
               deadCnt_d = '0;
            end
         endcase
      end
   end

   // Drop counter: add this cycle's discarded pulses with one spare bit to
   // catch overflow and pin the count at all-ones. A clear in the same cycle
   // wins over any increment.
   always_comb begin
      dropSum   = {1'b0, dropCnt_q} + (CNTW+1)'(dropInc);
      dropCnt_d = dropSum[CNTW-1:0];
      if (dropSum[CNTW]) begin
         dropCnt_d = '1;
      end
      if (drop_clr) begin
         dropCnt_d = '0;
      end
   end

   // All state registers share the asynchronous reset, so a pending trigger
   // is cancelled the instant reset rises.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         deadCnt_q <= '0;
         trigOut_q <= 1'b0;
         trigCh_q  <= '0;
         dropCnt_q <= '0;
      end else begin
         state_q   <= state_d;
         deadCnt_q <= deadCnt_d;
         trigOut_q <= trigOut_d;
         trigCh_q  <= trigCh_d;
         dropCnt_q <= dropCnt_d;
      end
   end

   // Outputs come straight from registers: the arm and busy flags are
   // decodes of the state register, the trigger has its own flops.
   assign valid_out  = {NCH{state_q == ARMED}};
   assign busy       = (state_q == DEAD);
   assign trig_out   = trigOut_q;
   assign trig_ch    = trigCh_q;
   assign drop_count = dropCnt_q;

endmodule

// File: tb/tb_trig_pulse_sched.sv
// ---------------------------------------------------------------------------
// tb_trig_pulse_sched
//
// Self-checking bench for trig_pulse_sched. A behavioural model tracks
// "armed", "dead cycles remaining" and the drop total; each scenario task
// drives the DUT and compares against it. A second instance with a 4-bit
// drop counter exercises saturation. Honours TRIG_RR_EN like the design.
// ---------------------------------------------------------------------------
module tb_trig_pulse_sched;

   localparam int NCH      = 4;
   localparam int DEADTIME = 16;
   localparam int CNTW     = 16;
   localparam int SCNTW    = 4;
   localparam int MAXA     = (1 << CNTW) - 1;
   localparam int MAXS     = (1 << SCNTW) - 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             enable;
   logic [NCH-1:0]   pulse_in;
   logic             drop_clr;
   logic [NCH-1:0]   valid_out;
   logic             trig_out;
   logic [1:0]       trig_ch;
   logic             busy;
   logic [CNTW-1:0]  drop_count;

   logic             satEnable;
   logic [NCH-1:0]   satPulse;
   logic             satClr;
   logic [NCH-1:0]   satValid;
   logic             satTrig;
   logic [1:0]       satCh;
   logic             satBusy;
   logic [SCNTW-1:0] satCount;

   int testCount = 0;
   int failCount = 0;

   // Behavioural model state
   bit mArmed;
   int mDeadLeft;
   bit mTrig;
   int mCh;
   int mDrops;
   int mPtr;
   int satDrops;

   always #5 clk = ~clk;

   trig_pulse_sched #(.NCH(NCH), .DEADTIME(DEADTIME), .CNTW(CNTW)) dut (
      .clk(clk), .reset(reset), .enable(enable), .pulse_in(pulse_in),
      .valid_out(valid_out), .trig_out(trig_out), .trig_ch(trig_ch),
      .busy(busy), .drop_clr(drop_clr), .drop_count(drop_count)
   );

   trig_pulse_sched #(.NCH(NCH), .DEADTIME(DEADTIME), .CNTW(SCNTW)) satDut (
      .clk(clk), .reset(reset), .enable(satEnable), .pulse_in(satPulse),
      .valid_out(satValid), .trig_out(satTrig), .trig_ch(satCh),
      .busy(satBusy), .drop_clr(satClr), .drop_count(satCount)
   );

   // Model reset: nothing armed, no dead time, counts and pointer cleared.
   task automatic modelReset();
      mArmed    = 1'b0;
      mDeadLeft = 0;
      mTrig     = 1'b0;
      mCh       = 0;
      mDrops    = 0;
      mPtr      = 0;
      satDrops  = 0;
   endtask

   // One clock of the scheduler rules: enable low disarms and drops all;
   // dead time drops all and re-arms once it has run out; idle arms; armed
   // with pulses triggers one channel and drops the rest.
   task automatic modelStep(input bit en, input logic [NCH-1:0] p, input bit clr);
      int pc;
      int g;
      bit found;
      pc    = $countones(p);
      mTrig = 1'b0;
      if (!en) begin
         mArmed    = 1'b0;
         mDeadLeft = 0;
         mDrops    = mDrops + pc;
      end else if (mDeadLeft > 0) begin
         mDrops    = mDrops + pc;
         mDeadLeft = mDeadLeft - 1;
         if (mDeadLeft == 0) mArmed = 1'b1;
      end else if (!mArmed) begin
         mArmed = 1'b1;
         mDrops = mDrops + pc;
      end else if (pc > 0) begin
         g     = 0;
         found = 1'b0;
`ifdef TRIG_RR_EN
         for (int i = 0; i < NCH; i++) begin
            int idx;
            idx = (mPtr + i) % NCH;
            if (!found && p[2'(idx)]) begin
               found = 1'b1;
               g     = idx;
            end
         end
         mPtr = (g + 1) % NCH;
`else
         for (int i = 0; i < NCH; i++) begin
            if (!found && p[2'(i)]) begin
               found = 1'b1;
               g     = i;
            end
         end
`endif
         mTrig     = 1'b1;
         mCh       = g;
         mArmed    = 1'b0;
         mDeadLeft = DEADTIME;
         mDrops    = mDrops + pc - 1;
      end
      if (mDrops > MAXA) mDrops = MAXA;
      if (clr) mDrops = 0;
   endtask

   function automatic logic [23:0] expVec();
      return {mArmed ? 4'hF : 4'h0, mDeadLeft > 0, mTrig,
              mTrig ? 2'(mCh) : 2'b00, 16'(mDrops)};
   endfunction

   function automatic logic [23:0] obsVec();
      return {valid_out, busy, trig_out, trig_out ? trig_ch : 2'b00, drop_count};
   endfunction

   // Drive inputs just after an edge, take the next edge, advance the model
   // and land 1 ns after that edge, where outputs are sampled.
   task automatic drive(input bit en, input logic [NCH-1:0] p, input bit clr);
      enable   = en;
      pulse_in = p;
      drop_clr = clr;
      @(posedge clk);
      modelStep(en, p, clr);
      #1;
   endtask

   // Synchronous-looking reset pulse for both instances, ending aligned.
   task automatic doReset();
      reset     = 1'b1;
      enable    = 1'b0;
      pulse_in  = '0;
      drop_clr  = 1'b0;
      satEnable = 1'b0;
      satPulse  = '0;
      satClr    = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      modelReset();
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      enable   = 1'b1;
      pulse_in = 4'b1111;
      @(posedge clk);
      #1;
      modelReset();
      testCount++;
      if ({valid_out, busy, trig_out, trig_ch, drop_count} !== 24'h0) begin
         failCount++;
         $display("[TB] FAIL reset_outputs: got %h, expected 000000",
                  {valid_out, busy, trig_out, trig_ch, drop_count});
      end
      testCount++;
      if (satCount !== 4'd0) begin
         failCount++;
         $display("[TB] FAIL reset_sat_count: got %0d, expected 0", satCount);
      end
      pulse_in = '0;
      enable   = 1'b0;
      reset    = 1'b0;
   endtask

   task automatic test_single_pulse();
      int busyCycles;
      doReset();
      drive(1'b1, 4'b0000, 1'b0);
      testCount++;
      if (obsVec() !== expVec()) begin
         failCount++;
         $display("[TB] FAIL single_arm: got %h, expected %h", obsVec(), expVec());
      end
      drive(1'b1, 4'b0100, 1'b0);
      testCount++;
      if (trig_out !== 1'b1 || trig_ch !== 2'd2 || busy !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL single_trig: trig_out=%b trig_ch=%0d busy=%b, expected 1/2/1",
                  trig_out, trig_ch, busy);
      end
      busyCycles = busy ? 1 : 0;
      for (int i = 1; i <= DEADTIME; i++) begin
         drive(1'b1, 4'b0000, 1'b0);
         if (busy) busyCycles++;
         testCount++;
         if (obsVec() !== expVec()) begin
            failCount++;
            $display("[TB] FAIL single_dead cyc %0d: got %h, expected %h", i, obsVec(), expVec());
         end
      end
      testCount++;
      if (busyCycles !== DEADTIME || valid_out !== 4'hF) begin
         failCount++;
         $display("[TB] FAIL single_deadtime: busy cycles %0d valid_out %h, expected %0d and F",
                  busyCycles, valid_out, DEADTIME);
      end
   endtask

   task automatic test_multi_pulse();
      logic [1:0] secondCh;
`ifdef TRIG_RR_EN
      secondCh = 2'd1;
`else
      secondCh = 2'd0;
`endif
      doReset();
      drive(1'b1, 4'b0000, 1'b0);
      drive(1'b1, 4'b1011, 1'b0);
      testCount++;
      if (trig_out !== 1'b1 || trig_ch !== 2'd0 || drop_count !== 16'd2) begin
         failCount++;
         $display("[TB] FAIL multi_first: trig=%b ch=%0d drops=%0d, expected 1/0/2",
                  trig_out, trig_ch, drop_count);
      end
      for (int i = 1; i <= DEADTIME; i++) begin
         drive(1'b1, 4'b0000, 1'b0);
         testCount++;
         if (obsVec() !== expVec()) begin
            failCount++;
            $display("[TB] FAIL multi_dead cyc %0d: got %h, expected %h", i, obsVec(), expVec());
         end
      end
      drive(1'b1, 4'b1011, 1'b0);
      testCount++;
      if (trig_out !== 1'b1 || trig_ch !== secondCh || drop_count !== 16'd4) begin
         failCount++;
         $display("[TB] FAIL multi_second: trig=%b ch=%0d drops=%0d, expected 1/%0d/4",
                  trig_out, trig_ch, drop_count, secondCh);
      end
   endtask

   task automatic test_dead_drops();
      int startDrops;
      startDrops = mDrops;
      for (int i = 1; i <= 2; i++) begin
         drive(1'b1, 4'b0001, 1'b0);
         testCount++;
         if (trig_out !== 1'b0 || obsVec() !== expVec()) begin
            failCount++;
            $display("[TB] FAIL dead_drop cyc %0d: got %h, expected %h", i, obsVec(), expVec());
         end
      end
      testCount++;
      if (int'(drop_count) !== startDrops + 2) begin
         failCount++;
         $display("[TB] FAIL dead_drop_total: got %0d, expected %0d", drop_count, startDrops + 2);
      end
      for (int i = 3; i <= DEADTIME; i++) begin
         drive(1'b1, 4'b0000, 1'b0);
         testCount++;
         if (obsVec() !== expVec()) begin
            failCount++;
            $display("[TB] FAIL dead_tail cyc %0d: got %h, expected %h", i, obsVec(), expVec());
         end
      end
   endtask

   task automatic test_enable_abort();
      drive(1'b1, 4'b0010, 1'b0);
      for (int i = 0; i < 4; i++) drive(1'b1, 4'b0000, 1'b0);
      drive(1'b0, 4'b0000, 1'b0);
      testCount++;
      if (valid_out !== 4'h0 || busy !== 1'b0 || trig_out !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL abort_idle: valid=%h busy=%b trig=%b, expected 0/0/0",
                  valid_out, busy, trig_out);
      end
      drive(1'b1, 4'b0000, 1'b0);
      testCount++;
      if (valid_out !== 4'hF || busy !== 1'b0 || trig_out !== 1'b0 || obsVec() !== expVec()) begin
         failCount++;
         $display("[TB] FAIL abort_rearm: got %h, expected %h", obsVec(), expVec());
      end
      drive(1'b1, 4'b0100, 1'b0);
      testCount++;
      if (trig_out !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL abort_pretrig: trig_out=%b, expected 1", trig_out);
      end
      // Reset lands mid-cycle with a trigger showing and dead time running.
      #2;
      reset = 1'b1;
      #1;
      testCount++;
      if ({valid_out, busy, trig_out, trig_ch, drop_count} !== 24'h0) begin
         failCount++;
         $display("[TB] FAIL async_reset: got %h, expected 000000",
                  {valid_out, busy, trig_out, trig_ch, drop_count});
      end
      @(posedge clk);
      #1;
      testCount++;
      if (trig_out !== 1'b0 || busy !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL reset_hold: trig=%b busy=%b, expected 0/0", trig_out, busy);
      end
      reset = 1'b0;
      modelReset();
      drive(1'b1, 4'b0000, 1'b0);
      drive(1'b0, 4'b0110, 1'b0);
      testCount++;
      if (trig_out !== 1'b0 || valid_out !== 4'h0 || drop_count !== 16'd2) begin
         failCount++;
         $display("[TB] FAIL disable_with_pulse: trig=%b valid=%h drops=%0d, expected 0/0/2",
                  trig_out, valid_out, drop_count);
      end
   endtask

   task automatic test_saturation();
      doReset();
      for (int i = 1; i <= 20; i++) begin
         satPulse = 4'b0001;
         drive(1'b0, 4'b0000, 1'b0);
         satDrops = (satDrops + 1 > MAXS) ? MAXS : satDrops + 1;
         testCount++;
         if (int'(satCount) !== satDrops) begin
            failCount++;
            $display("[TB] FAIL sat_count step %0d: got %0d, expected %0d", i, satCount, satDrops);
         end
      end
      satPulse = 4'b1111;
      satClr   = 1'b1;
      drive(1'b0, 4'b0000, 1'b0);
      satDrops = 0;
      testCount++;
      if (satCount !== 4'd0) begin
         failCount++;
         $display("[TB] FAIL sat_clear: got %0d, expected 0", satCount);
      end
      satClr   = 1'b0;
      satPulse = 4'b0011;
      drive(1'b0, 4'b0000, 1'b0);
      satPulse = 4'b0000;
      testCount++;
      if (satCount !== 4'd2) begin
         failCount++;
         $display("[TB] FAIL sat_after_clear: got %0d, expected 2", satCount);
      end
   endtask

   task automatic test_random();
      bit en;
      bit clr;
      logic [NCH-1:0] p;
      doReset();
      for (int i = 0; i < 600; i++) begin
         en  = ($urandom_range(0, 19) != 0);
         p   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
         clr = ($urandom_range(0, 49) == 0);
         drive(en, p, clr);
         testCount++;
         if (obsVec() !== expVec()) begin
            failCount++;
            $display("[TB] FAIL random cyc %0d: got %h, expected %h", i, obsVec(), expVec());
         end
      end
   endtask

   // Scenario sequence; each task leaves the clock aligned 1 ns past an edge.
   initial begin
      reset     = 1'b1;
      enable    = 1'b0;
      pulse_in  = '0;
      drop_clr  = 1'b0;
      satEnable = 1'b0;
      satPulse  = '0;
      satClr    = 1'b0;
      modelReset();
      test_reset();
      test_single_pulse();
      test_multi_pulse();
      test_dead_drops();
      test_enable_abort();
      test_saturation();
      test_random();
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
